// File: rtl/io_access_arbiter.sv
// Round-robin arbiter sharing the IO module register-access port between two masters.
// Each access takes IDLE -> ACCESS -> DONE; the ack pulses in DONE with the captured read value.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; winner latched on the accepting edge
// ACCESS | io_addr/io_wdata driven, io_we asserted for mapped writes
// DONE   | winner's ack pulses, rdata/err already updated
module io_access_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic                  io_we,
  output logic [ADDR_WIDTH-1:0] io_addr,
  output logic [DATA_WIDTH-1:0] io_wdata,
  input  logic [DATA_WIDTH-1:0] io_read_data,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_UNMAPPED = ADDR_WIDTH'(3);

  state_t state, state_next;
  logic   last_grant;
  logic   lat_we;
  logic   winner;
  logic   accept;
  logic   unmapped;

  // On a tie the master not served last wins; otherwise the lone requester.
  assign winner   = (m0_req && m1_req) ? ~last_grant : m1_req;
  assign unmapped = (io_addr == ADDR_UNMAPPED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    io_we      = 1'b0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        io_we      = lat_we && !unmapped;
        state_next = DONE;
      end
      DONE: begin
        m0_ack     = ~grant;
        m1_ack     = grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      io_addr    <= '0;
      io_wdata   <= '0;
      m0_rdata   <= '0;
      m0_err     <= 1'b0;
      m1_rdata   <= '0;
      m1_err     <= 1'b0;
    end else begin
      if (accept) begin
        grant      <= winner;
        last_grant <= winner;
        lat_we     <= winner ? m1_we    : m0_we;
        io_addr    <= winner ? m1_addr  : m0_addr;
        io_wdata   <= winner ? m1_wdata : m0_wdata;
      end
      // Read value is captured on writes too; it is the pre-write contents.
      if (state == ACCESS) begin
        if (grant) begin
          m1_rdata <= unmapped ? '0 : io_read_data;
          m1_err   <= unmapped;
        end else begin
          m0_rdata <= unmapped ? '0 : io_read_data;
          m0_err   <= unmapped;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_access_arbiter.sv
// Bench for io_access_arbiter: a register-bank stand-in for the IO module, a transaction-level
// model checked against the DUT every cycle, and directed scenarios with literal expectations.
module tb_io_access_arbiter;
  localparam int DW = 64;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = 0, m1_addr = 0;
  logic [DW-1:0] m0_wdata = 0, m1_wdata = 0;
  logic          m0_ack, m1_ack, m0_err, m1_err, io_we, busy, grant;
  logic [DW-1:0] m0_rdata, m1_rdata, io_wdata, io_read_data;
  logic [AW-1:0] io_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_read_data(io_read_data), .busy(busy), .grant(grant)
  );

  // IO module stand-in; slot 3 holds junk so an unmapped read must be zeroed by the arbiter.
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = 0;
  logic [DW-1:0] pl_data = 0;
  logic [DW-1:0] regs [4] = '{64'h0, 64'h0, 64'h0, 64'hBAD0_BAD0_BAD0_BAD0};
  assign io_read_data = regs[io_addr];
  always @(posedge clk) begin
    if (pl_en) regs[pl_addr] <= pl_data;
    else if (io_we) regs[io_addr] <= io_wdata;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted request occupies the edge it was taken on (access window),
  // the next edge (completion, ack window) and the one after (return to idle).
  logic [DW-1:0] mregs [4] = '{64'h0, 64'h0, 64'h0, 64'h0};
  int            edge_n = 0, t_start = 0;
  bit            m_active = 0, can_take = 0;
  logic          m_last = 1'b1, m_grant = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_wdata = 0, m_rd0 = 0, m_rd1 = 0, m_v = 0;
  logic          m_er0 = 0, m_er1 = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_n = 0; m_active = 0; m_last = 1'b1; m_grant = 1'b0; m_we = 1'b0;
      m_addr = 0; m_wdata = 0; m_rd0 = 0; m_rd1 = 0; m_er0 = 0; m_er1 = 0;
    end else begin
      edge_n++;
      if (pl_en) mregs[pl_addr] = pl_data;
      if (m_active && edge_n == t_start + 1) begin
        m_v = (m_addr == 2'd3) ? 64'h0 : mregs[m_addr];
        if (m_grant) begin m_rd1 = m_v; m_er1 = (m_addr == 2'd3); end
        else         begin m_rd0 = m_v; m_er0 = (m_addr == 2'd3); end
        if (m_we && m_addr != 2'd3) mregs[m_addr] = m_wdata;
      end
      can_take = !m_active;
      if (m_active && edge_n == t_start + 2) m_active = 0;
      if (can_take && (m0_req || m1_req)) begin
        if (m0_req && m1_req) m_grant = ~m_last;
        else                  m_grant = m1_req;
        m_last   = m_grant;
        m_we     = m_grant ? m1_we    : m0_we;
        m_addr   = m_grant ? m1_addr  : m0_addr;
        m_wdata  = m_grant ? m1_wdata : m0_wdata;
        m_active = 1;
        t_start  = edge_n;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy",     busy,     m_active);
      chk("io_we",    io_we,    m_active && edge_n == t_start && m_we && m_addr != 2'd3);
      chk("io_addr",  io_addr,  m_addr);
      chk("io_wdata", io_wdata, m_wdata);
      chk("grant",    grant,    m_grant);
      chk("m0_ack",   m0_ack,   m_active && edge_n == t_start + 1 && !m_grant);
      chk("m1_ack",   m1_ack,   m_active && edge_n == t_start + 1 && m_grant);
      chk("m0_rdata", m0_rdata, m_rd0);
      chk("m1_rdata", m1_rdata, m_rd1);
      chk("m0_err",   m0_err,   m_er0);
      chk("m1_err",   m1_err,   m_er1);
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one access and returns how many negedges after raising req the ack was seen.
  task automatic access(input int m, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat);
    @(negedge clk);
    if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin lat = i; break; end
    end
    m0_req = 0; m1_req = 0;
    if (lat == 0) chk("ack_timeout", 0, 1);
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  int lat;
  int a0[$], a1[$];

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_io_addr", io_addr, 0);
    chk("rst_m0_rdata", m0_rdata, 0);

    // single read of control register
    preload(2'd1, 64'hA5);
    access(0, 0, 2'd1, 64'h0, lat);
    chk("read_lat", lat, 2);
    chk("read_m0_rdata", m0_rdata, 64'hA5);
    chk("read_m0_err", m0_err, 0);

    // single write to data_io
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_addr = 2'd0; m1_wdata = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_io_we", io_we, 1);
    chk("wr_io_addr", io_addr, 0);
    chk("wr_io_wdata", io_wdata, 64'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_m1_ack", m1_ack, 1);
    chk("wr_io_we_done", io_we, 0);
    m1_req = 0; m1_we = 0;

    // contention with both held: m0, m1, m0, m1
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 2'd1;
    m1_req = 1; m1_we = 0; m1_addr = 2'd0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (m0_ack) a0.push_back(i);
      if (m1_ack) a1.push_back(i);
    end
    m0_req = 0; m1_req = 0;
    chk("cont_m0_cnt", a0.size(), 2);
    chk("cont_m1_cnt", a1.size(), 2);
    chk("cont_m0_first", qget(a0, 0), 2);
    chk("cont_m1_first", qget(a1, 0), 5);
    chk("cont_m0_second", qget(a0, 1), 8);
    chk("cont_m1_second", qget(a1, 1), 11);
    chk("cont_m1_rdata", m1_rdata, 64'hDEAD_BEEF);

    // unmapped write then read
    access(0, 1, 2'd3, 64'hFFFF_0000_FFFF_0000, lat);
    chk("unm_wr_err", m0_err, 1);
    chk("unm_wr_rdata", m0_rdata, 0);
    access(0, 0, 2'd3, 64'h0, lat);
    chk("unm_rd_err", m0_err, 1);
    chk("unm_rd_rdata", m0_rdata, 0);

    // interrupt read by m1; m0 result untouched
    preload(2'd2, 64'h1);
    access(1, 0, 2'd2, 64'h0, lat);
    chk("irq_m1_rdata", m1_rdata, 64'h1);
    chk("irq_m1_err", m1_err, 0);
    chk("irq_m0_rdata", m0_rdata, 0);
    chk("irq_m0_err", m0_err, 1);

    // req dropped mid-transaction still completes
    @(negedge clk);
    m1_req = 1; m1_we = 0; m1_addr = 2'd1;
    @(negedge clk);
    m1_req = 0;
    @(negedge clk);
    chk("drop_m1_ack", m1_ack, 1);
    chk("drop_m1_rdata", m1_rdata, 64'hA5);

    // reset in ACCESS aborts the write
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 2'd0; m0_wdata = 64'h5;
    @(posedge clk);
    #2;
    chk("rst_mid_io_we_before", io_we, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_io_we", io_we, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_m0_ack", m0_ack, 0);
    m0_req = 0; m0_we = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // first tie after reset goes to m0
    @(negedge clk);
    m0_req = 1; m0_addr = 2'd0; m1_req = 1; m1_addr = 2'd2;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin lat = m1_ack ? 100 + i : i; break; end
    end
    m0_req = 0; m1_req = 0;
    chk("tie_after_reset", lat, 2);
    chk("aborted_write_absent", m0_rdata, 64'hDEAD_BEEF);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
